multi_alarm_setter: RTL and testbench

MULTI_ALARM_SETTER -- requirements
Module: multi_alarm_setter

---
 rtl/alarm_pkg.sv | 24 ++
 rtl/key_repeater.sv | 48 ++++
 rtl/multi_alarm_setter.sv | 98 +++++++++
 tb/tb_multi_alarm_setter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared constants and the 7-segment lookup for the alarm setter.
package alarm_pkg;
  localparam int MAX_HOURS   = 24;
  localparam int MAX_MINUTES = 60;

  // Segment order {a,b,c,d,e,f,g,dp}, active high; dp is left clear here.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hE6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/key_repeater.sv
// Debounced key with auto-repeat: one step after the press, then after
// HOLD_CYC, then every REPEAT_CYC while the key stays down.
module key_repeater #(
  parameter int DEBOUNCE_CYC = 10000,
  parameter int HOLD_CYC     = 200000000,
  parameter int REPEAT_CYC   = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic step
);
  localparam int MAXC = (HOLD_CYC > REPEAT_CYC) ?
                        ((HOLD_CYC > DEBOUNCE_CYC) ? HOLD_CYC : DEBOUNCE_CYC) :
                        ((REPEAT_CYC > DEBOUNCE_CYC) ? REPEAT_CYC : DEBOUNCE_CYC);
  localparam int TW = $clog2(MAXC + 1);

  logic [TW-1:0] dcnt, tmr;
  logic          pressed, rep;

  // tmr counts down to the next step; the first step lands one cycle after
  // the press flag is seen, hence the initial load of 1.
  always_ff @(posedge clk) begin
    if (reset || !key) begin
      dcnt    <= '0;
      tmr     <= '0;
      pressed <= 1'b0;
      rep     <= 1'b0;
      step    <= 1'b0;
    end else if (!pressed) begin
      step <= 1'b0;
      if (dcnt == TW'(DEBOUNCE_CYC - 1)) begin
        pressed <= 1'b1;
        tmr     <= TW'(1);
        rep     <= 1'b0;
      end else begin
        dcnt <= dcnt + TW'(1);
      end
    end else if (tmr == '0) begin
      step <= 1'b1;
      rep  <= 1'b1;
      tmr  <= rep ? TW'(REPEAT_CYC - 1) : TW'(HOLD_CYC - 1);
    end else begin
      step <= 1'b0;
      tmr  <= tmr - TW'(1);
    end
  end
endmodule

// File: rtl/multi_alarm_setter.sv
// Multi-slot alarm time editor with inc/dec keys and a 4-digit scanned display.
module multi_alarm_setter import alarm_pkg::*; #(
  parameter int N_SLOTS      = 4,
  parameter int DEBOUNCE_CYC = 10000,
  parameter int HOLD_CYC     = 200000000,
  parameter int REPEAT_CYC   = 25000000,
  parameter int SCAN_CYC     = 20000
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          set_mode,
  input  logic [(N_SLOTS > 1 ? $clog2(N_SLOTS) : 1)-1:0] slot_sel,
  input  logic                                          field_sel,
  input  logic                                          increase_key,
  input  logic                                          decrease_key,
  input  logic                                          visible,
  output logic [7:0]                                    tub_segments_1,
  output logic [7:0]                                    tub_select,
  output logic [4:0]                                    hours,
  output logic [5:0]                                    minutes,
  output logic [5*N_SLOTS-1:0]                          slot_hours_flat,
  output logic [6*N_SLOTS-1:0]                          slot_minutes_flat
);
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CW = $clog2(SCAN_CYC + 1);
  localparam logic [4:0] H_TOP = 5'(MAX_HOURS - 1);
  localparam logic [5:0] M_TOP = 6'(MAX_MINUTES - 1);

  logic          inc_step, dec_step;
  logic [4:0]    hrs  [N_SLOTS];
  logic [5:0]    mins [N_SLOTS];
  logic          sel_ok;
  logic [SW-1:0] sel;
  logic [1:0]    scan_idx;
  logic [CW-1:0] scan_cnt;
  logic [3:0]    digit;
  logic          dp;

  key_repeater #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC))
    u_inc (.clk(clk), .reset(reset), .key(increase_key), .step(inc_step));
  key_repeater #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC))
    u_dec (.clk(clk), .reset(reset), .key(decrease_key), .step(dec_step));

  // Out-of-range slot numbers fall back to slot 0 for display and are not editable.
  assign sel_ok = (32'(slot_sel) < N_SLOTS);
  assign sel    = sel_ok ? slot_sel : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        hrs[k]  <= 5'd10;
        mins[k] <= 6'd0;
      end
    end else if (set_mode && sel_ok && (inc_step ^ dec_step)) begin
      if (field_sel)
        hrs[sel] <= inc_step ? ((hrs[sel] == H_TOP) ? 5'd0 : hrs[sel] + 5'd1)
                             : ((hrs[sel] == 5'd0) ? H_TOP : hrs[sel] - 5'd1);
      else
        mins[sel] <= inc_step ? ((mins[sel] == M_TOP) ? 6'd0 : mins[sel] + 6'd1)
                              : ((mins[sel] == 6'd0) ? M_TOP : mins[sel] - 6'd1);
    end
  end

  assign hours   = hrs[sel];
  assign minutes = mins[sel];

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_flat
    assign slot_hours_flat[5*k +: 5]   = hrs[k];
    assign slot_minutes_flat[6*k +: 6] = mins[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= 2'd0;
    end else if (scan_cnt == CW'(SCAN_CYC - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  always_comb begin
    digit = 4'd0;
    case (scan_idx)
      2'd0:    digit = 4'(hours / 5'd10);
      2'd1:    digit = 4'(hours % 5'd10);
      2'd2:    digit = 4'(minutes / 6'd10);
      default: digit = 4'(minutes % 6'd10);
    endcase
  end

  // Digits 0/1 are hours, 2/3 minutes; dp marks the field under edit.
  assign dp             = set_mode && (field_sel == (scan_idx < 2'd2));
  assign tub_select     = (visible && !reset) ? (8'h80 >> scan_idx) : 8'h00;
  assign tub_segments_1 = (visible && !reset) ? (seg7(digit) | {7'b0, dp}) : 8'h00;
endmodule

// File: tb/tb_multi_alarm_setter.sv
// Randomized and directed check of multi_alarm_setter against a behavioural model.
module tb_multi_alarm_setter;
  localparam int D = 4, H = 20, R = 5, S = 3, NS = 4;

  logic        clk = 1'b0;
  logic        reset, set_mode, field_sel, increase_key, decrease_key, visible;
  logic [1:0]  slot_sel;
  logic [7:0]  tub_segments_1, tub_select;
  logic [4:0]  hours;
  logic [5:0]  minutes;
  logic [19:0] slot_hours_flat;
  logic [23:0] slot_minutes_flat;

  multi_alarm_setter #(.N_SLOTS(NS), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R), .SCAN_CYC(S))
    dut (.clk(clk), .reset(reset), .set_mode(set_mode), .slot_sel(slot_sel), .field_sel(field_sel),
         .increase_key(increase_key), .decrease_key(decrease_key), .visible(visible),
         .tub_segments_1(tub_segments_1), .tub_select(tub_select), .hours(hours), .minutes(minutes),
         .slot_hours_flat(slot_hours_flat), .slot_minutes_flat(slot_minutes_flat));

  always #5 clk = ~clk;

  int tests = 0, failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run lengths of high key samples decide when steps fire.
  int mh[NS], mm[NS];
  int run_i = 0, run_d = 0, t = 0;
  bit pend_i = 0, pend_d = 0, armed = 0;
  logic [7:0] lut[10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};

  function automatic bit fires(input int n);
    if (n == D + 2) return 1'b1;
    if (n >= D + 2 + H && ((n - D - 2 - H) % R) == 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NS; k++) begin mh[k] = 10; mm[k] = 0; end
      run_i = 0; run_d = 0; pend_i = 0; pend_d = 0; t = 0; armed = 1;
    end else begin
      if (set_mode && (pend_i != pend_d)) begin
        if (field_sel) mh[slot_sel] = (mh[slot_sel] + (pend_i ? 1 : 23)) % 24;
        else           mm[slot_sel] = (mm[slot_sel] + (pend_i ? 1 : 59)) % 60;
      end
      run_i  = increase_key ? run_i + 1 : 0;
      run_d  = decrease_key ? run_d + 1 : 0;
      pend_i = fires(run_i);
      pend_d = fires(run_d);
      t++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (armed) begin
      int h, m, idx, dig;
      logic [19:0] eh;
      logic [23:0] em;
      logic [7:0]  es, eg;
      bit          edp;
      h = mh[slot_sel]; m = mm[slot_sel]; idx = (t / S) % 4;
      case (idx)
        0: dig = h / 10;
        1: dig = h % 10;
        2: dig = m / 10;
        default: dig = m % 10;
      endcase
      edp = set_mode && (field_sel ? (idx < 2) : (idx >= 2));
      es  = (visible && !reset) ? (8'h80 >> idx) : 8'h00;
      eg  = (visible && !reset) ? (lut[dig] | {7'b0, edp}) : 8'h00;
      for (int k = 0; k < NS; k++) begin
        eh[5*k +: 5] = 5'(mh[k]);
        em[6*k +: 6] = 6'(mm[k]);
      end
      chk("m_hours", hours, h);
      chk("m_minutes", minutes, m);
      chk("m_hflat", slot_hours_flat, eh);
      chk("m_mflat", slot_minutes_flat, em);
      chk("m_tubsel", tub_select, es);
      chk("m_tubseg", tub_segments_1, eg);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Key(s) high for n sampled edges, then released with time to settle.
  task automatic press(input bit inc, input bit dec, input int n);
    increase_key = inc; decrease_key = dec;
    cyc(n);
    increase_key = 0; decrease_key = 0;
    cyc(3);
  endtask

  task automatic scan_check(input logic [7:0] s3, input logic [7:0] s4);
    logic [7:0] ts[4] = '{8'h80, 8'h40, 8'h20, 8'h10};
    logic [7:0] sg[4];
    int n = 0;
    sg = '{8'h60, 8'hDA, s3, s4};
    while (tub_select == 8'h80 && n < 20) begin cyc(1); n++; end
    while (tub_select != 8'h80 && n < 20) begin cyc(1); n++; end
    for (int i = 0; i < 4; i++) begin
      chk("scan_sel", tub_select, ts[i]);
      chk("scan_seg", tub_segments_1, sg[i]);
      cyc(3);
    end
    chk("scan_wrap", tub_select, 8'h80);
  endtask

  initial begin
    reset = 1; set_mode = 0; slot_sel = 0; field_sel = 0;
    increase_key = 0; decrease_key = 0; visible = 1;
    cyc(2);
    chk("rst_tubsel", tub_select, 8'h00);
    chk("rst_tubseg", tub_segments_1, 8'h00);
    chk("rst_hflat", slot_hours_flat, {4{5'd10}});
    chk("rst_mflat", slot_minutes_flat, 24'd0);
    reset = 0; set_mode = 1; slot_sel = 2; field_sel = 0;
    press(1, 0, 3);
    chk("short_pulse", minutes, 6'd0);
    press(1, 0, 10);
    chk("one_step_min", minutes, 6'd1);
    chk("one_step_flat", slot_minutes_flat, {6'd0, 6'd1, 6'd0, 6'd0});
    field_sel = 1;
    press(1, 0, 4 + 1 + 20 + 5 + 5);
    chk("hold_3_steps", hours, 5'd13);
    slot_sel = 0; field_sel = 0;
    press(0, 1, 10);
    chk("min_wrap_dn", minutes, 6'd59);
    press(1, 0, 10);
    chk("min_wrap_up", minutes, 6'd0);
    chk("min_wrap_hrs", hours, 5'd10);
    field_sel = 1;
    repeat (10) press(0, 1, 8);
    chk("hrs_to_zero", hours, 5'd0);
    press(0, 1, 8);
    chk("hrs_wrap_dn", hours, 5'd23);
    press(1, 1, 10);
    chk("both_cancel", hours, 5'd23);
    set_mode = 0;
    press(1, 0, 10);
    chk("mode_off", hours, 5'd23);
    set_mode = 1; slot_sel = 1;
    repeat (2) press(1, 0, 8);
    field_sel = 0;
    repeat (34) press(1, 0, 8);
    chk("slot1_hm", {hours, minutes}, {5'd12, 6'd34});
    set_mode = 0;
    scan_check(8'hF2, 8'h66);
    set_mode = 1; field_sel = 0;
    scan_check(8'hF3, 8'h67);
    slot_sel = 3; field_sel = 1;
    increase_key = 1;
    cyc(28);
    reset = 1;
    cyc(1);
    reset = 0;
    chk("midhold_rst_h", slot_hours_flat, {4{5'd10}});
    chk("midhold_rst_m", slot_minutes_flat, 24'd0);
    cyc(4);
    chk("rst_redebounce", hours, 5'd10);
    cyc(4);
    increase_key = 0;
    cyc(2);
    chk("fresh_press", hours, 5'd11);
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) increase_key = !increase_key;
      if ($urandom_range(0, 19) == 0) decrease_key = !decrease_key;
      if ($urandom_range(0, 49) == 0) set_mode = !set_mode;
      if ($urandom_range(0, 29) == 0) slot_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) field_sel = !field_sel;
      if ($urandom_range(0, 29) == 0) visible = !visible;
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
